bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-port round-robin memory bus arbiter. Each transfer takes WAIT_CYC access
// cycles and is followed by a one-cycle completion acknowledge.
//
//   state  | meaning
//   IDLE   | no transfer; sample requests and pick a winner
//   ACCESS | memory strobe active for WAIT_CYC cycles using latched request
//   DONE   | ack pulse to the winner; winner becomes last_served
module bus_arbiter #(
  parameter int ADR_W    = 6,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADR_W-1:0]  adr0,
  input  logic [ADR_W-1:0]  adr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADR_W-1:0]  adr_bus,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                last_served;
  logic                winner;
  logic                pick;
  logic                we_l;
  logic [ADR_W-1:0]    adr_l;
  logic [DATA_W-1:0]   wdata_l;

  // On a tie the port that was not served last wins.
  assign pick = req1 & (~req0 | ~last_served);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 | req1) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 4'd0;
      last_served <= 1'b1;
      winner      <= 1'b0;
      we_l        <= 1'b0;
      adr_l       <= '0;
      wdata_l     <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            winner  <= pick;
            we_l    <= pick ? we1 : we0;
            adr_l   <= pick ? adr1 : adr0;
            wdata_l <= pick ? wdata1 : wdata0;
            cnt     <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_l) begin
              if (winner) rdata1 <= mem_rdata;
              else        rdata0 <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    last_served <= winner;
        default: ;
      endcase
    end
  end

  always_comb begin
    adr_bus   = '0;
    mem_wdata = '0;
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = (state != IDLE);
    grant_id  = winner;
    if (state == ACCESS) begin
      adr_bus   = adr_l;
      mem_wdata = wdata_l;
      rd_mem    = ~we_l;
      wr_mem    = we_l;
    end
    if (state == DONE) begin
      ack0 = ~winner;
      ack1 = winner;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with WAIT_CYC = 2.
module tb_bus_arbiter;

  localparam int ADR_W    = 6;
  localparam int DATA_W   = 8;
  localparam int WAIT_CYC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADR_W-1:0]  adr0, adr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADR_W-1:0]  adr_bus;
  logic              rd_mem, wr_mem;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy, grant_id;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Mutual-exclusion invariants, checked every cycle away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (rd_mem && wr_mem) begin
      errors++;
      $display("FAIL excl_strobe rd_mem=%0b wr_mem=%0b required not both", rd_mem, wr_mem);
    end
    checks++;
    if (ack0 && ack1) begin
      errors++;
      $display("FAIL excl_ack ack0=%0b ack1=%0b required not both", ack0, ack1);
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, grant_id, rd_mem, wr_mem, ack0, ack1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 000000",
               {busy, grant_id, rd_mem, wr_mem, ack0, ack1});
    end
    checks++;
    if (rdata0 !== 8'h00 || rdata1 !== 8'h00 || adr_bus !== 6'h00 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_data rdata0=%h rdata1=%h adr_bus=%h mem_wdata=%h required all 0",
               rdata0, rdata1, adr_bus, mem_wdata);
    end
    reset = 1'b0;
  endtask

  // Single read on port 0 with an address change mid-transfer.
  task automatic test_read();
    req0 = 1; we0 = 0; adr0 = 6'h05; mem_rdata = 8'hA7;
    for (int c = 1; c <= WAIT_CYC; c++) begin
      @(negedge clk);
      req0 = 0;
      adr0 = 6'h10;
      checks++;
      if (rd_mem !== 1'b1 || wr_mem !== 1'b0 || adr_bus !== 6'h05 || busy !== 1'b1 || grant_id !== 1'b0) begin
        errors++;
        $display("FAIL read_access%0d rd=%b wr=%b adr=%h busy=%b gid=%b required 1 0 05 1 0",
                 c, rd_mem, wr_mem, adr_bus, busy, grant_id);
      end
    end
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || rd_mem !== 1'b0 || busy !== 1'b1 || adr_bus !== 6'h10 - 6'h10) begin
      errors++;
      $display("FAIL read_done ack0=%b ack1=%b rd=%b busy=%b adr=%h required 1 0 0 1 00",
               ack0, ack1, rd_mem, busy, adr_bus);
    end
    checks++;
    if (rdata0 !== 8'hA7) begin
      errors++;
      $display("FAIL read_rdata0 got %h required a7", rdata0);
    end
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b0 || adr_bus !== 6'h00 || rdata0 !== 8'hA7 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL read_idle ack0=%b busy=%b adr=%h rdata0=%h gid=%b required 0 0 00 a7 0",
               ack0, busy, adr_bus, rdata0, grant_id);
    end
  endtask

  // Single write on port 1; rdata1 must stay at its reset value.
  task automatic test_write();
    req1 = 1; we1 = 1; adr1 = 6'h3F; wdata1 = 8'h5C; mem_rdata = 8'hEE;
    for (int c = 1; c <= WAIT_CYC; c++) begin
      @(negedge clk);
      req1 = 0;
      wdata1 = 8'h11;
      checks++;
      if (wr_mem !== 1'b1 || rd_mem !== 1'b0 || adr_bus !== 6'h3F || mem_wdata !== 8'h5C || grant_id !== 1'b1) begin
        errors++;
        $display("FAIL write_access%0d wr=%b rd=%b adr=%h wd=%h gid=%b required 1 0 3f 5c 1",
                 c, wr_mem, rd_mem, adr_bus, mem_wdata, grant_id);
      end
    end
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || wr_mem !== 1'b0 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL write_done ack1=%b ack0=%b wr=%b wd=%h required 1 0 0 00",
               ack1, ack0, wr_mem, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (rdata1 !== 8'h00 || rdata0 !== 8'hA7 || grant_id !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_idle rdata1=%h rdata0=%h gid=%b busy=%b required 00 a7 1 0",
               rdata1, rdata0, grant_id, busy);
    end
  endtask

  // Held tie after reset alternates 0,1,0,1 with single-cycle acks.
  task automatic test_tie();
    logic exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int   n_ack = 0;
    logic prev_ack = 1'b0;
    test_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; mem_rdata = 8'h3C;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        checks++;
        if (prev_ack) begin
          errors++;
          $display("FAIL tie_pulse ack lasted 2 cycles at ack %0d required 1 cycle", n_ack);
        end
        checks++;
        if (ack1 !== exp_id[n_ack] || grant_id !== exp_id[n_ack]) begin
          errors++;
          $display("FAIL tie_order ack %0d got port %b gid %b required %b",
                   n_ack, ack1, grant_id, exp_id[n_ack]);
        end
        n_ack++;
        if (n_ack == 4) begin
          req0 = 0; req1 = 0;
        end
      end
      prev_ack = ack0 | ack1;
    end
    checks++;
    if (n_ack != 4) begin
      errors++;
      $display("FAIL tie_timeout got %0d acks required 4", n_ack);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rdata0 !== 8'h3C || rdata1 !== 8'h3C) begin
      errors++;
      $display("FAIL tie_idle busy=%b rdata0=%h rdata1=%h required 0 3c 3c", busy, rdata0, rdata1);
    end
  endtask

  // Port 0 held: ack-to-ack spacing is WAIT_CYC+2.
  task automatic test_back_to_back();
    int t_ack [2];
    int n_ack = 0;
    req0 = 1; we0 = 0; mem_rdata = 8'h42;
    for (int c = 0; c < 30 && n_ack < 2; c++) begin
      @(negedge clk);
      if (ack0) begin
        t_ack[n_ack] = c;
        n_ack++;
        if (n_ack == 2) req0 = 0;
      end
    end
    checks++;
    if (n_ack != 2) begin
      errors++;
      $display("FAIL b2b_timeout got %0d acks required 2", n_ack);
    end else begin
      checks++;
      if (t_ack[1] - t_ack[0] != WAIT_CYC + 2) begin
        errors++;
        $display("FAIL b2b_spacing got %0d required %0d", t_ack[1] - t_ack[0], WAIT_CYC + 2);
      end
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rdata0 !== 8'h42 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle rdata0=%h busy=%b required 42 0", rdata0, busy);
    end
  endtask

  // Reset during 2nd ACCESS cycle; last transfer was port 0, so the
  // following tie going to port 0 proves last_served was reset to 1.
  task automatic test_reset_abort();
    req0 = 1; we0 = 0; adr0 = 6'h05; mem_rdata = 8'h99;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    checks++;
    if (rd_mem !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre rd_mem=%b required 1", rd_mem);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rd_mem !== 1'b0 || ack0 !== 1'b0 || busy !== 1'b0 || rdata0 !== 8'h00 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL abort_state rd=%b ack0=%b busy=%b rdata0=%h gid=%b required 0 0 0 00 0",
               rd_mem, ack0, busy, rdata0, grant_id);
    end
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; adr0 = 6'h21; adr1 = 6'h12; wdata0 = 8'hC3;
    @(negedge clk);
    req0 = 0; req1 = 0;
    checks++;
    if (grant_id !== 1'b0 || wr_mem !== 1'b1 || adr_bus !== 6'h21 || mem_wdata !== 8'hC3) begin
      errors++;
      $display("FAIL abort_tie gid=%b wr=%b adr=%h wd=%h required 0 1 21 c3",
               grant_id, wr_mem, adr_bus, mem_wdata);
    end
    repeat (WAIT_CYC) @(negedge clk);
    checks++;
    if (ack0 !== 1'b1 || rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL abort_tie_done ack0=%b rdata0=%h required 1 00", ack0, rdata0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish required finish");
    $fatal(1);
  end

endmodule
